aq_bju_redirect_ctrl: RTL and testbench

- Consumer end of the BJU address-generator interface.
- Takes the EX1 branch/jump target computed by the address generator and resolves the actual next PC.
- Compares the actual next PC against the front-end prediction; on a mismatch, registers a change-of-flow request and drives it to the IFU over a valid/ack handshake.
- Stalls IDU issue while a redirect is outstanding and keeps a saturating mispredict counter for performance monitoring.

---
 rtl/aq_bju_pkg.sv | 14 +
 rtl/aq_bju_mispred_cmp.sv | 32 +++
 rtl/aq_bju_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_aq_bju_redirect_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_bju_pkg.sv
// Shared types and constants for the BJU redirect controller.
// Holds the redirect FSM encoding, the default PC width and the instruction-length increments.
package aq_bju_pkg;

  localparam int AQ_PC_WIDTH = 40;
  localparam int AQ_INC_16   = 2;
  localparam int AQ_INC_32   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } bju_state_e;

endpackage

// File: rtl/aq_bju_mispred_cmp.sv
// Combinational EX1 resolve: computes the actual next PC and flags a front-end mispredict.
// Zero latency; no flow control of its own.
module aq_bju_mispred_cmp
  import aq_bju_pkg::*;
#(
  parameter int PC_WIDTH = AQ_PC_WIDTH
) (
  input  logic                is_jmp,
  input  logic                cond_taken,
  input  logic                pred_taken,
  input  logic                inst_32,
  input  logic [PC_WIDTH-1:0] pred_pc,
  input  logic [PC_WIDTH-1:0] cur_pc,
  input  logic [PC_WIDTH-1:1] ag_pc,
  output logic                act_taken,
  output logic [PC_WIDTH-1:0] act_pc,
  output logic                mispred
);

  logic [PC_WIDTH-1:0] tgt;
  logic [PC_WIDTH-1:0] seq;

  always_comb begin
    act_taken = is_jmp | cond_taken;
    tgt       = {ag_pc, 1'b0};
    // Fall-through PC wraps at the top of the PC space.
    seq       = cur_pc + (inst_32 ? PC_WIDTH'(AQ_INC_32) : PC_WIDTH'(AQ_INC_16));
    act_pc    = act_taken ? tgt : seq;
    mispred   = (act_taken != pred_taken) | (act_taken & pred_taken & (tgt != pred_pc));
  end

endmodule

// File: rtl/aq_bju_redirect_ctrl.sv
// BJU redirect controller: registers a change-of-flow on EX1 mispredict (1-cycle latency), holds it until IFU ack,
// stalls IDU while outstanding, counts mispredicts. AQ_BJU_MISALIGN_CHK_EN enables the target-misalign exception.
module aq_bju_redirect_ctrl
  import aq_bju_pkg::*;
#(
  parameter int PC_WIDTH  = AQ_PC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 idu_bju_ex1_sel,
  input  logic                 bju_ex1_is_jmp,
  input  logic                 bju_ex1_cond_taken,
  input  logic                 bju_ex1_pred_taken,
  input  logic [PC_WIDTH-1:0]  bju_ex1_pred_pc,
  input  logic [PC_WIDTH-1:0]  bju_ex1_cur_pc,
  input  logic                 bju_ex1_inst_32,
  input  logic [63:0]          ag_bju_pc,
  input  logic                 rtu_yy_xx_flush,
  input  logic                 ifu_bju_chgflw_ack,
  output logic                 bju_ifu_chgflw_vld,
  output logic [PC_WIDTH-1:0]  bju_ifu_chgflw_pc,
  output logic                 bju_idu_ex1_stall,
  output logic                 bju_ex1_expt_vld,
  output logic [CNT_WIDTH-1:0] bju_pmu_mispred_cnt
);

  bju_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                cnt_inc;
  logic                act_taken;
  logic [PC_WIDTH-1:0] act_pc;
  logic                mispred;
  logic                accept;
  logic                misalign;
  logic                redir_go;

  aq_bju_mispred_cmp #(
    .PC_WIDTH (PC_WIDTH)
  ) u_cmp (
    .is_jmp     (bju_ex1_is_jmp),
    .cond_taken (bju_ex1_cond_taken),
    .pred_taken (bju_ex1_pred_taken),
    .inst_32    (bju_ex1_inst_32),
    .pred_pc    (bju_ex1_pred_pc),
    .cur_pc     (bju_ex1_cur_pc),
    .ag_pc      (ag_bju_pc[PC_WIDTH-1:1]),
    .act_taken  (act_taken),
    .act_pc     (act_pc),
    .mispred    (mispred)
  );

  assign accept = idu_bju_ex1_sel & (state_q == IDLE) & ~rtu_yy_xx_flush;

`ifdef AQ_BJU_MISALIGN_CHK_EN
  logic expt_q;
  logic unused_ag_bits;

  // A misaligned taken target traps instead of redirecting.
  assign misalign       = act_taken & ag_bju_pc[1];
  assign unused_ag_bits = ^{ag_bju_pc[63:PC_WIDTH], ag_bju_pc[0]};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) expt_q <= 1'b0;
    else        expt_q <= accept & misalign;
  end

  assign bju_ex1_expt_vld = expt_q;
`else
  logic unused_ag_bits;

  assign misalign         = 1'b0;
  assign unused_ag_bits   = ^{ag_bju_pc[63:PC_WIDTH], ag_bju_pc[0], act_taken};
  assign bju_ex1_expt_vld = 1'b0;
`endif

  assign redir_go = accept & mispred & ~misalign;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (redir_go) begin
          state_d = REDIR;
          pc_d    = act_pc;
        end
      end
      REDIR: begin
        // Ack wins over a simultaneous flush: the transfer already happened.
        if (ifu_bju_chgflw_ack) begin
          state_d = IDLE;
          cnt_inc = 1'b1;
        end else if (rtu_yy_xx_flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)                                 cnt_q <= '0;
    else if (cnt_inc && (cnt_q != '1))          cnt_q <= cnt_q + 1'b1;
  end

  assign bju_ifu_chgflw_vld  = (state_q == REDIR);
  assign bju_idu_ex1_stall   = (state_q == REDIR);
  assign bju_ifu_chgflw_pc   = pc_q;
  assign bju_pmu_mispred_cnt = cnt_q;

endmodule

// File: tb/tb_aq_bju_redirect_ctrl.sv
// Directed bench for aq_bju_redirect_ctrl; expected redirect targets are queued at stimulus time and popped on vld.
// Counter width is reduced so saturation is reachable in a short run.
module tb_aq_bju_redirect_ctrl;

  localparam int PW = 40;
  localparam int CW = 6;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst;
  logic          idu_bju_ex1_sel;
  logic          bju_ex1_is_jmp;
  logic          bju_ex1_cond_taken;
  logic          bju_ex1_pred_taken;
  logic [PW-1:0] bju_ex1_pred_pc;
  logic [PW-1:0] bju_ex1_cur_pc;
  logic          bju_ex1_inst_32;
  logic [63:0]   ag_bju_pc;
  logic          rtu_yy_xx_flush;
  logic          ifu_bju_chgflw_ack;
  logic          bju_ifu_chgflw_vld;
  logic [PW-1:0] bju_ifu_chgflw_pc;
  logic          bju_idu_ex1_stall;
  logic          bju_ex1_expt_vld;
  logic [CW-1:0] bju_pmu_mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [PW-1:0] sb_q[$];

  always #5 forever_cpuclk = ~forever_cpuclk;

  aq_bju_redirect_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .forever_cpuclk      (forever_cpuclk),
    .cpurst              (cpurst),
    .idu_bju_ex1_sel     (idu_bju_ex1_sel),
    .bju_ex1_is_jmp      (bju_ex1_is_jmp),
    .bju_ex1_cond_taken  (bju_ex1_cond_taken),
    .bju_ex1_pred_taken  (bju_ex1_pred_taken),
    .bju_ex1_pred_pc     (bju_ex1_pred_pc),
    .bju_ex1_cur_pc      (bju_ex1_cur_pc),
    .bju_ex1_inst_32     (bju_ex1_inst_32),
    .ag_bju_pc           (ag_bju_pc),
    .rtu_yy_xx_flush     (rtu_yy_xx_flush),
    .ifu_bju_chgflw_ack  (ifu_bju_chgflw_ack),
    .bju_ifu_chgflw_vld  (bju_ifu_chgflw_vld),
    .bju_ifu_chgflw_pc   (bju_ifu_chgflw_pc),
    .bju_idu_ex1_stall   (bju_idu_ex1_stall),
    .bju_ex1_expt_vld    (bju_ex1_expt_vld),
    .bju_pmu_mispred_cnt (bju_pmu_mispred_cnt)
  );

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected redirect target and compare it with the DUT's current request.
  task automatic chk_redir(input string tag);
    logic [PW-1:0] e;
    chk({tag, "_vld"}, 64'(bju_ifu_chgflw_vld), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(bju_ifu_chgflw_pc), 64'hDEAD);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"}, 64'(bju_ifu_chgflw_pc), 64'(e));
    end
  endtask

  task automatic drive(input logic jmp, input logic cond, input logic pred,
                       input logic [PW-1:0] ppc, input logic [PW-1:0] cpc,
                       input logic i32, input logic [63:0] ag);
    idu_bju_ex1_sel    = 1'b1;
    bju_ex1_is_jmp     = jmp;
    bju_ex1_cond_taken = cond;
    bju_ex1_pred_taken = pred;
    bju_ex1_pred_pc    = ppc;
    bju_ex1_cur_pc     = cpc;
    bju_ex1_inst_32    = i32;
    ag_bju_pc          = ag;
  endtask

  initial begin
    cpurst = 1'b1; idu_bju_ex1_sel = 1'b0; bju_ex1_is_jmp = 1'b0; bju_ex1_cond_taken = 1'b0;
    bju_ex1_pred_taken = 1'b0; bju_ex1_pred_pc = '0; bju_ex1_cur_pc = '0; bju_ex1_inst_32 = 1'b0;
    ag_bju_pc = '0; rtu_yy_xx_flush = 1'b0; ifu_bju_chgflw_ack = 1'b0;
    step(); step();
    cpurst = 1'b0;
    step();
    chk("rst_vld",   64'(bju_ifu_chgflw_vld), 64'd0);
    chk("rst_pc",    64'(bju_ifu_chgflw_pc), 64'd0);
    chk("rst_stall", 64'(bju_idu_ex1_stall), 64'd0);
    chk("rst_expt",  64'(bju_ex1_expt_vld), 64'd0);
    chk("rst_cnt",   64'(bju_pmu_mispred_cnt), 64'd0);

    // Mispredicted taken branch, ack after 3 cycles.
    drive(1'b0, 1'b1, 1'b0, '0, 40'h1000, 1'b1, 64'h2000);
    sb_q.push_back(40'h2000);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t1");
    chk("t1_stall", 64'(bju_idu_ex1_stall), 64'd1);
    step();
    chk("t1_hold_vld", 64'(bju_ifu_chgflw_vld), 64'd1);
    chk("t1_hold_pc",  64'(bju_ifu_chgflw_pc), 64'h2000);
    step();
    chk("t1_hold_cnt", 64'(bju_pmu_mispred_cnt), 64'd0);
    ifu_bju_chgflw_ack = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0;
    chk("t1_ack_vld",   64'(bju_ifu_chgflw_vld), 64'd0);
    chk("t1_ack_stall", 64'(bju_idu_ex1_stall), 64'd0);
    chk("t1_cnt",       64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Mispredicted not-taken 16-bit at the top of the PC space: fall-through wraps to 0.
    drive(1'b0, 1'b0, 1'b1, 40'h123, 40'hFF_FFFF_FFFE, 1'b0, 64'h5550);
    sb_q.push_back(40'h0);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t2");
    ifu_bju_chgflw_ack = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0;
    chk("t2_cnt", 64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Correct prediction; address-generator bits above the PC width must not matter.
    drive(1'b1, 1'b0, 1'b1, 40'h3000, 40'h100, 1'b1, 64'hABCD_0000_0000_3000);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk("t3_vld",   64'(bju_ifu_chgflw_vld), 64'd0);
    chk("t3_stall", 64'(bju_idu_ex1_stall), 64'd0);
    step();
    chk("t3_cnt",   64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Wrong taken target with correct direction.
    drive(1'b0, 1'b1, 1'b1, 40'h3000, 40'h100, 1'b1, 64'h3010);
    sb_q.push_back(40'h3010);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t3b");
    // Flush during REDIR without ack.
    rtu_yy_xx_flush = 1'b1;
    step();
    rtu_yy_xx_flush = 1'b0;
    chk("t4_vld",   64'(bju_ifu_chgflw_vld), 64'd0);
    chk("t4_stall", 64'(bju_idu_ex1_stall), 64'd0);
    chk("t4_cnt",   64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Back-to-back: second branch held by IDU during REDIR, accepted after ack.
    drive(1'b0, 1'b1, 1'b0, '0, 40'h400, 1'b1, 64'h5000);
    sb_q.push_back(40'h5000);
    step();
    drive(1'b1, 1'b0, 1'b0, '0, 40'h404, 1'b1, 64'h6000);
    sb_q.push_back(40'h6000);
    chk_redir("t5a");
    step();
    chk("t5_stall_pc", 64'(bju_ifu_chgflw_pc), 64'h5000);
    ifu_bju_chgflw_ack = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0;
    chk("t5_gap_vld", 64'(bju_ifu_chgflw_vld), 64'd0);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t5b");
    ifu_bju_chgflw_ack = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0;
    chk("t5_cnt", 64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Flush and ack together still count.
    drive(1'b0, 1'b1, 1'b0, '0, 40'h700, 1'b1, 64'h7000);
    sb_q.push_back(40'h7000);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t6");
    ifu_bju_chgflw_ack = 1'b1; rtu_yy_xx_flush = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0; rtu_yy_xx_flush = 1'b0;
    chk("t6_vld", 64'(bju_ifu_chgflw_vld), 64'd0);
    chk("t6_cnt", 64'(bju_pmu_mispred_cnt), 64'(exp_cnt));

    // Flush in the accept cycle suppresses the redirect.
    drive(1'b0, 1'b1, 1'b0, '0, 40'h800, 1'b1, 64'h8000);
    rtu_yy_xx_flush = 1'b1;
    step();
    idu_bju_ex1_sel = 1'b0; rtu_yy_xx_flush = 1'b0;
    chk("t7_vld", 64'(bju_ifu_chgflw_vld), 64'd0);

    // Taken jump to a halfword-aligned target.
    drive(1'b1, 1'b0, 1'b0, '0, 40'h900, 1'b1, 64'h1002);
`ifdef AQ_BJU_MISALIGN_CHK_EN
    step();
    idu_bju_ex1_sel = 1'b0;
    chk("t8_expt", 64'(bju_ex1_expt_vld), 64'd1);
    chk("t8_vld",  64'(bju_ifu_chgflw_vld), 64'd0);
    step();
    chk("t8_expt_pulse", 64'(bju_ex1_expt_vld), 64'd0);
    chk("t8_cnt",  64'(bju_pmu_mispred_cnt), 64'(exp_cnt));
`else
    sb_q.push_back(40'h1002);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t8");
    chk("t8_expt", 64'(bju_ex1_expt_vld), 64'd0);
    ifu_bju_chgflw_ack = 1'b1;
    step(); exp_cnt++;
    ifu_bju_chgflw_ack = 1'b0;
    chk("t8_cnt", 64'(bju_pmu_mispred_cnt), 64'(exp_cnt));
`endif

    // Reset while a redirect is outstanding.
    drive(1'b0, 1'b1, 1'b0, '0, 40'hA00, 1'b1, 64'hA000);
    sb_q.push_back(40'hA000);
    step();
    idu_bju_ex1_sel = 1'b0;
    chk_redir("t9");
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    chk("t9_vld", 64'(bju_ifu_chgflw_vld), 64'd0);
    chk("t9_cnt", 64'(bju_pmu_mispred_cnt), 64'd0);

    // Saturation: two cycles per redirect with ack held high.
    drive(1'b0, 1'b1, 1'b0, '0, 40'hB00, 1'b1, 64'hB000);
    ifu_bju_chgflw_ack = 1'b1;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      step(); step();
    end
    chk("sat_max", 64'(bju_pmu_mispred_cnt), 64'h3F);
    for (int i = 0; i < 4; i++) begin
      step(); step();
    end
    chk("sat_hold", 64'(bju_pmu_mispred_cnt), 64'h3F);
    idu_bju_ex1_sel = 1'b0; ifu_bju_chgflw_ack = 1'b0;
    step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
